// File: rtl/pipo_load_arbiter.sv
// Arbitrates NREQ requesters onto a shared PIPO register's pipo_in/load pins.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module pipo_load_arbiter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  localparam int unsigned IdW        = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [WIDTH-1:0]        pipo_in,
  output logic                    load,
  output logic [NREQ-1:0]         ack,
  output logic [IdW-1:0]          grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StAck} state_e;

  state_e           state;
  logic [3:0]       hold_cnt;
  logic [IdW-1:0]   winner;
  logic             found;
  logic [WIDTH-1:0] win_data;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req[IdW'(i)] && !found) begin
        winner = IdW'(i);
        found  = 1'b1;
      end
    end
  end
`else
  logic [IdW-1:0] last_grant;
  logic [IdW-1:0] idx;

  // Search starts just past the previous grantee and wraps.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = IdW'((int'(last_grant) + k) % int'(NREQ));
      if (req[idx] && !found) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  // Only the winner's slice is ever selected, so idle requesters' data cannot leak X.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IdW'(i) == winner) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      hold_cnt <= '0;
      pipo_in  <= '0;
      load     <= 1'b0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant <= IdW'(NREQ - 1);
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (found) begin
            grant_id <= winner;
            pipo_in  <= win_data;
            load     <= 1'b1;
            busy     <= 1'b1;
            state    <= StLoad;
          end
        end
        StLoad: begin
          load     <= 1'b0;
          hold_cnt <= '0;
          state    <= StHold;
        end
        StHold: begin
          if (hold_cnt == 4'(HOLD_CYCLES - 1)) begin
            ack   <= NREQ'(1) << grant_id;
            state <= StAck;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        StAck: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= StIdle;
`ifndef ARB_FIXED_PRIO_EN
          last_grant <= grant_id;
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter (WIDTH=4, NREQ=4, HOLD_CYCLES=2).
module tb_pipo_load_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  pipo_in;
  logic        load;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipo_load_arbiter #(.WIDTH(4), .NREQ(4), .HOLD_CYCLES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .pipo_in  (pipo_in),
    .load     (load),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] data;
    logic        load;
    logic [3:0]  pipo;
    logic [3:0]  ack;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pipo_in"}, 32'(pipo_in), 0);
    chk({tag, ".load"}, 32'(load), 0);
    chk({tag, ".ack"}, 32'(ack), 0);
    chk({tag, ".grant_id"}, 32'(grant_id), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  // Apply inputs, take one rising edge, settle.
  task automatic step(input logic [3:0] r, input logic [15:0] d);
    req      = r;
    req_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t vecs[16];
  int   gids[$];
  int   gdat[$];
  int   gcyc[$];
  int   exp4[4];
  int   ack3_cnt;

  initial begin
    // Transaction for req[1], then req[2] with data change in HOLD, then req[0] waiting during HOLD.
    vecs[0]  = '{4'b0010, 16'h0090, 1, 4'h9, 4'b0000, 2'd1, 1};
    vecs[1]  = '{4'b0000, 16'h0000, 0, 4'h9, 4'b0000, 2'd1, 1};
    vecs[2]  = '{4'b0000, 16'h0000, 0, 4'h9, 4'b0000, 2'd1, 1};
    vecs[3]  = '{4'b0000, 16'h0000, 0, 4'h9, 4'b0010, 2'd1, 1};
    vecs[4]  = '{4'b0000, 16'h0000, 0, 4'h9, 4'b0000, 2'd1, 0};
    vecs[5]  = '{4'b0000, 16'h0000, 0, 4'h9, 4'b0000, 2'd1, 0};
    vecs[6]  = '{4'b0100, 16'h0500, 1, 4'h5, 4'b0000, 2'd2, 1};
    vecs[7]  = '{4'b0100, 16'h0500, 0, 4'h5, 4'b0000, 2'd2, 1};
    vecs[8]  = '{4'b0001, 16'h0F03, 0, 4'h5, 4'b0000, 2'd2, 1};
    vecs[9]  = '{4'b0001, 16'h0F03, 0, 4'h5, 4'b0100, 2'd2, 1};
    vecs[10] = '{4'b0001, 16'h0F03, 0, 4'h5, 4'b0000, 2'd2, 0};
    vecs[11] = '{4'b0001, 16'h0F03, 1, 4'h3, 4'b0000, 2'd0, 1};
    vecs[12] = '{4'b0000, 16'h0000, 0, 4'h3, 4'b0000, 2'd0, 1};
    vecs[13] = '{4'b0000, 16'h0000, 0, 4'h3, 4'b0000, 2'd0, 1};
    vecs[14] = '{4'b0000, 16'h0000, 0, 4'h3, 4'b0001, 2'd0, 1};
    vecs[15] = '{4'b0000, 16'h0000, 0, 4'h3, 4'b0000, 2'd0, 0};

    // Reset asserted with random req: outputs must already be clear.
    req      = 4'($urandom);
    req_data = 16'($urandom);
    #3;
    chk_zero("reset_async");
    do_reset();
    chk_zero("reset_release");

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].req, vecs[i].data);
      chk($sformatf("vec%0d.load", i), 32'(load), 32'(vecs[i].load));
      chk($sformatf("vec%0d.pipo_in", i), 32'(pipo_in), 32'(vecs[i].pipo));
      chk($sformatf("vec%0d.ack", i), 32'(ack), 32'(vecs[i].ack));
      chk($sformatf("vec%0d.grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // All four requesting: rotation and 5-cycle load spacing.
    do_reset();
    for (int c = 0; c < 30 && gids.size() < 5; c++) begin
      step(4'b1111, 16'h8421);
      if (load) begin
        gids.push_back(int'(grant_id));
        gdat.push_back(int'(pipo_in));
        gcyc.push_back(c);
      end
    end
    chk("rr_all.count", 32'(gids.size()), 5);
    for (int i = 0; i < gids.size() && i < 5; i++) begin
      chk($sformatf("rr_all.gid%0d", i), 32'(gids[i]), 32'(i % 4));
      chk($sformatf("rr_all.data%0d", i), 32'(gdat[i]), 32'(1 << (i % 4)));
      if (i > 0) chk($sformatf("rr_all.gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 5);
    end

    // req[0] and req[2] held continuously.
`ifdef ARB_FIXED_PRIO_EN
    exp4 = '{0, 0, 0, 0};
`else
    exp4 = '{0, 2, 0, 2};
`endif
    do_reset();
    gids.delete();
    ack3_cnt = 0;
    for (int c = 0; c < 30 && gids.size() < 4; c++) begin
      step(4'b0101, 16'h0A0B);
      if (load) gids.push_back(int'(grant_id));
    end
    chk("pair.count", 32'(gids.size()), 4);
    for (int i = 0; i < gids.size() && i < 4; i++)
      chk($sformatf("pair.gid%0d", i), 32'(gids[i]), 32'(exp4[i]));

    // Kill a grant to req[3] in HOLD; no ack[3] afterwards, requester 0 first.
    do_reset();
    step(4'b1000, 16'h5000);
    chk("kill.grant", 32'(grant_id), 3);
    step(4'b1000, 16'h5000);
    step(4'b1000, 16'h5000);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("kill.mid");
    @(negedge clk);
    reset = 1'b1;
    step(4'b1001, 16'h5003);
    chk("kill.first_load", 32'(load), 1);
    chk("kill.first_gid", 32'(grant_id), 0);
    chk("kill.first_data", 32'(pipo_in), 3);
    for (int c = 0; c < 5; c++) begin
      step(4'b0000, 16'h0000);
      if (ack[3]) ack3_cnt++;
    end
    chk("kill.no_ack3", 32'(ack3_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
